// File: rtl/ddr_axi_traffic_checker_if.sv
// AXI4 write/read channel bundle between the traffic checker (master) and the DDR controller (slave).
// Latency: pure wiring, no storage.
// Backpressure: standard AXI valid/ready on every channel.
interface ddr_axi_traffic_checker_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arlen, arvalid, input arready,
        input  rdata, rlast, rvalid, output rready
    );

    modport slave (
        input  awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arlen, arvalid, output arready,
        output rdata, rlast, rvalid, input rready
    );
endinterface

// File: rtl/ddr_axi_traffic_checker.sv
// Self-test AXI4 master: writes a burst, reads it back, compares, and loops over a fixed window.
// Latency: one burst in flight; a new AW is issued 2 cycles after the final R beat.
// Backpressure: valid and payload held until ready; always ready on B and R. Macro PRBS_PATTERN_EN selects LFSR data.
module ddr_axi_traffic_checker #(
    parameter int              ADDR_WIDTH = 28,
    parameter int              DATA_WIDTH = 256,
    parameter int              BURST_LEN  = 16,
    parameter longint unsigned TEST_BASE  = 0,
    parameter int              TEST_SPAN  = 1024,
    parameter int              HEART_DIV  = 50000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ddr_init_done,
    ddr_axi_traffic_checker_if.master axi,
    output logic                      err_flag,
    output logic [15:0]               err_cnt,
    output logic [15:0]               pass_cnt,
    output logic                      heart_beat,
    output logic                      test_busy
);
    localparam int         LANES       = DATA_WIDTH / 32;
    localparam int         BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);
    localparam logic [7:0] BEAT_LAST   = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT, S_AW, S_W, S_B, S_AR, S_R, S_NEXT
    } state_t;

    state_t                state;
    logic [11:0]           burst_idx;
    logic [7:0]            beat;
    logic [31:0]           hb_cnt;
    logic [DATA_WIDTH-1:0] exp_rdata;
    logic [1:0]            err_inc;
    logic [16:0]           err_sum;

    // Both address channels point at the current burst; burst_idx only moves in NEXT, so they stay stable.
    assign axi.awaddr = ADDR_WIDTH'(64'(TEST_BASE) + 64'(burst_idx) * 64'(BURST_BYTES));
    assign axi.araddr = ADDR_WIDTH'(64'(TEST_BASE) + 64'(burst_idx) * 64'(BURST_BYTES));
    assign axi.awlen  = BEAT_LAST;
    assign axi.arlen  = BEAT_LAST;
    assign axi.wstrb  = '1;
    assign test_busy  = (state != S_WAIT_INIT);

`ifdef PRBS_PATTERN_EN
    logic [DATA_WIDTH-1:0] wr_lfsr;
    logic [DATA_WIDTH-1:0] rd_lfsr;

    // Per-lane Fibonacci LFSR for x^32+x^22+x^2+x+1.
    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] n;
        logic [31:0]           l;
        n = '0;
        for (int j = 0; j < LANES; j++) begin
            l = s[j*32 +: 32];
            n[j*32 +: 32] = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        return n;
    endfunction

    // Seed from burst/pass/lane; the all-zero lock-up state is replaced by 1.
    function automatic logic [DATA_WIDTH-1:0] lfsr_seed(input logic [11:0] bi, input logic [15:0] pc);
        logic [DATA_WIDTH-1:0] n;
        logic [31:0]           l;
        n = '0;
        for (int j = 0; j < LANES; j++) begin
            l = {bi, pc, 4'(j)};
            n[j*32 +: 32] = (l == 32'd0) ? 32'd1 : l;
        end
        return n;
    endfunction

    // Write and read generators restart identically at burst start and step on their own accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_lfsr <= '0;
            rd_lfsr <= '0;
        end else if (state == S_AW) begin
            wr_lfsr <= lfsr_seed(burst_idx, pass_cnt);
            rd_lfsr <= lfsr_seed(burst_idx, pass_cnt);
        end else begin
            if (state == S_W && axi.wready) wr_lfsr <= lfsr_step(wr_lfsr);
            if (state == S_R && axi.rvalid) rd_lfsr <= lfsr_step(rd_lfsr);
        end
    end

    assign axi.wdata = wr_lfsr;
    assign exp_rdata = rd_lfsr;
`else
    // Lane j of beat i carries {pass[7:0], burst[11:0], beat[7:0], lane[3:0]}.
    function automatic logic [DATA_WIDTH-1:0] count_pattern(input logic [7:0] pc, input logic [11:0] bi,
                                                            input logic [7:0] bt);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int j = 0; j < LANES; j++) d[j*32 +: 32] = {pc, bi, bt, 4'(j)};
        return d;
    endfunction

    assign axi.wdata = count_pattern(pass_cnt[7:0], burst_idx, beat);
    assign exp_rdata = count_pattern(pass_cnt[7:0], burst_idx, beat);
`endif

    // Error events this cycle: a data mismatch and an rlast error on one beat count separately.
    always_comb begin
        err_inc = 2'd0;
        if (state == S_R && axi.rvalid)
            err_inc = 2'(axi.rdata != exp_rdata) + 2'(axi.rlast != (beat == BEAT_LAST));
        if (state == S_B && axi.bvalid && axi.bresp != 2'b00)
            err_inc = 2'd1;
    end

    assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

    // Main sequencer: one burst written, acknowledged, read back and checked, then the next burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT_INIT;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.wlast   <= 1'b0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            burst_idx   <= '0;
            pass_cnt    <= '0;
            beat        <= '0;
            err_cnt     <= '0;
            err_flag    <= 1'b0;
        end else begin
            if (err_inc != 2'd0) begin
                err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                err_flag <= 1'b1;
            end
            case (state)
                S_WAIT_INIT: if (ddr_init_done) begin
                    state       <= S_AW;
                    axi.awvalid <= 1'b1;
                end
                S_AW: if (axi.awready) begin
                    axi.awvalid <= 1'b0;
                    axi.wvalid  <= 1'b1;
                    axi.wlast   <= (BEAT_LAST == 8'd0);
                    beat        <= '0;
                    state       <= S_W;
                end
                S_W: if (axi.wready) begin
                    if (beat == BEAT_LAST) begin
                        axi.wvalid <= 1'b0;
                        axi.wlast  <= 1'b0;
                        axi.bready <= 1'b1;
                        beat       <= '0;
                        state      <= S_B;
                    end else begin
                        beat      <= beat + 8'd1;
                        axi.wlast <= (beat + 8'd1 == BEAT_LAST);
                    end
                end
                S_B: if (axi.bvalid) begin
                    axi.bready  <= 1'b0;
                    axi.arvalid <= 1'b1;
                    state       <= S_AR;
                end
                S_AR: if (axi.arready) begin
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b1;
                    beat        <= '0;
                    state       <= S_R;
                end
                S_R: if (axi.rvalid) begin
                    if (beat == BEAT_LAST) begin
                        axi.rready <= 1'b0;
                        beat       <= '0;
                        state      <= S_NEXT;
                    end else begin
                        beat <= beat + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (burst_idx == 12'(TEST_SPAN - 1)) begin
                        burst_idx <= '0;
                        pass_cnt  <= pass_cnt + 16'd1;
                    end else begin
                        burst_idx <= burst_idx + 12'd1;
                    end
                    if (ddr_init_done) begin
                        axi.awvalid <= 1'b1;
                        state       <= S_AW;
                    end else begin
                        state <= S_WAIT_INIT;
                    end
                end
                default: state <= S_WAIT_INIT;
            endcase
        end
    end

    // Heartbeat: steady 1 once an error is seen, 0 until the controller is calibrated, otherwise a slow blink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt     <= '0;
            heart_beat <= 1'b0;
        end else if (err_flag) begin
            hb_cnt     <= '0;
            heart_beat <= 1'b1;
        end else if (!ddr_init_done) begin
            hb_cnt     <= '0;
            heart_beat <= 1'b0;
        end else if (hb_cnt == 32'(HEART_DIV - 1)) begin
            hb_cnt     <= '0;
            heart_beat <= ~heart_beat;
        end else begin
            hb_cnt <= hb_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_ddr_axi_traffic_checker.sv
// Bench for ddr_axi_traffic_checker: negedge-driven AXI slave with a memory, error injection and per-beat checks.
// Scenario table covers clean runs, stalls and injected errors; hand sequences cover idle, init drop and reset mid-W.
// Slave inputs change only on the falling edge; DUT outputs are sampled there too.
module tb_ddr_axi_traffic_checker;
    localparam int AW   = 28;
    localparam int DW   = 256;
    localparam int BL   = 16;
    localparam int SPAN = 4;
    localparam int HDIV = 20;
    localparam int BB   = DW / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ddr_init_done = 1'b0;
    logic        err_flag;
    logic [15:0] err_cnt;
    logic [15:0] pass_cnt;
    logic        heart_beat;
    logic        test_busy;

    ddr_axi_traffic_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    ddr_axi_traffic_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .TEST_BASE(0),
        .TEST_SPAN(SPAN), .HEART_DIV(HDIV)
    ) dut (
        .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done), .axi(axi),
        .err_flag(err_flag), .err_cnt(err_cnt), .pass_cnt(pass_cnt),
        .heart_beat(heart_beat), .test_busy(test_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_beat(input int p, input int b, input int i);
        logic [DW-1:0] d;
        logic [7:0]    pp;
        logic [11:0]   bb;
        logic [7:0]    ii;
        pp = p[7:0];
        bb = b[11:0];
        ii = i[7:0];
        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = {pp, bb, ii, 4'(j)};
        return d;
    endfunction

    // Injection / stall configuration written by the stimulus process.
    int stall = 0, corrupt_burst = -1, corrupt_beat = 0, bresp_burst = -1, early_burst = -1;

    // Slave-side bookkeeping.
    logic [DW-1:0]   mem [0:SPAN*BL-1];
    logic [DW-1:0]   rd;
    logic [BB-1:0]   all_ones = '1;
    int cyc = 0, exp_burst = 0, exp_pass = 0, wbase = 0, wbeat = 0, rbase = 0, rbeat = 0;
    int last_r_cyc = -1;
    bit w_active = 0, b_pend = 0, r_active = 0, awv_prev = 0;
    bit aw_stall_prev = 0, ar_stall_prev = 0, w_stall_prev = 0, wl_prev = 0;
    logic [1:0]    b_resp_q = 2'b00;
    logic [AW-1:0] aw_prev, ar_prev;
    logic [DW-1:0] wd_prev;

    // AXI slave model: drive on the falling edge, then account for the handshakes of the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            axi.awready = 0; axi.wready = 0; axi.arready = 0;
            axi.bvalid = 0; axi.bresp = 2'b00;
            axi.rvalid = 0; axi.rlast = 0; axi.rdata = '0;
            exp_burst = 0; exp_pass = 0; wbeat = 0; rbeat = 0;
            w_active = 0; b_pend = 0; r_active = 0; last_r_cyc = -1; awv_prev = 0;
            aw_stall_prev = 0; ar_stall_prev = 0; w_stall_prev = 0;
        end else begin
            axi.awready = (stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            axi.wready  = (stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            axi.arready = (stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            axi.bvalid  = b_pend;
            axi.bresp   = b_resp_q;
            if (r_active && (stall == 0 || $urandom_range(0, 1) == 1)) begin
                rd = mem[rbase + rbeat];
                if (exp_pass == 0 && exp_burst == corrupt_burst && rbeat == corrupt_beat) rd[0] = ~rd[0];
                axi.rvalid = 1;
                axi.rdata  = rd;
                axi.rlast  = (rbeat == BL - 1) || (exp_pass == 0 && exp_burst == early_burst && rbeat == BL - 2);
            end else begin
                axi.rvalid = 0; axi.rlast = 0; axi.rdata = '0;
            end

            if (aw_stall_prev) check("aw_hold", DW'({axi.awvalid, axi.awaddr}), DW'({1'b1, aw_prev}));
            if (ar_stall_prev) check("ar_hold", DW'({axi.arvalid, axi.araddr}), DW'({1'b1, ar_prev}));
            if (w_stall_prev) begin
                check("w_hold_ctl", DW'({axi.wvalid, axi.wlast}), DW'({1'b1, wl_prev}));
                check("w_hold_data", axi.wdata, wd_prev);
            end
            if (axi.awvalid && !awv_prev && last_r_cyc >= 0) begin
                check("aw_latency", DW'(cyc - last_r_cyc), DW'(2));
                last_r_cyc = -1;
            end

            if (axi.awvalid && axi.awready) begin
                check("awaddr", DW'(axi.awaddr), DW'(AW'(exp_burst * BL * BB)));
                check("awlen", DW'(axi.awlen), DW'(BL - 1));
                w_active = 1; wbeat = 0; wbase = exp_burst * BL;
            end
            if (axi.wvalid && axi.wready) begin
                check("w_in_burst", DW'(w_active), DW'(1));
                if (wbeat == 0) check("wstrb", DW'(axi.wstrb), DW'(all_ones));
`ifndef PRBS_PATTERN_EN
                check("wdata", axi.wdata, exp_beat(exp_pass, exp_burst, wbeat));
`endif
                check("wlast", DW'(axi.wlast), DW'(wbeat == BL - 1));
                if (wbeat < BL) mem[wbase + wbeat] = axi.wdata;
                wbeat++;
                if (wbeat >= BL) begin
                    w_active = 0; b_pend = 1;
                    b_resp_q = (exp_pass == 0 && exp_burst == bresp_burst) ? 2'b10 : 2'b00;
                end
            end
            if (axi.bvalid && axi.bready) begin
                b_pend = 0; b_resp_q = 2'b00;
            end
            if (axi.arvalid && axi.arready) begin
                check("araddr", DW'(axi.araddr), DW'(AW'(exp_burst * BL * BB)));
                check("arlen", DW'(axi.arlen), DW'(BL - 1));
                r_active = 1; rbeat = 0; rbase = exp_burst * BL;
            end
            if (axi.rvalid && axi.rready) begin
                rbeat++;
                if (rbeat == BL) begin
                    r_active = 0;
                    if (ddr_init_done) last_r_cyc = cyc;
                    if (exp_burst == SPAN - 1) begin
                        exp_burst = 0; exp_pass++;
                    end else begin
                        exp_burst++;
                    end
                end
            end

            aw_stall_prev = axi.awvalid && !axi.awready; aw_prev = axi.awaddr;
            ar_stall_prev = axi.arvalid && !axi.arready; ar_prev = axi.araddr;
            w_stall_prev  = axi.wvalid && !axi.wready;   wd_prev = axi.wdata; wl_prev = axi.wlast;
            awv_prev      = axi.awvalid;
        end
    end

    typedef struct {
        int stall;
        int corrupt_burst;
        int corrupt_beat;
        int bresp_burst;
        int early_burst;
        int exp_err;
        bit exp_flag;
    } vec_t;

    vec_t vecs[6];

    task automatic do_reset();
        rst = 1; ddr_init_done = 0;
        repeat (3) @(negedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_cond_pass1(input int limit);
        for (int c = 0; c < limit; c++) begin
            if (pass_cnt == 16'd1) break;
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int viol, hi, tog;
        logic hb_prev;
        bit hit;

        vecs[0] = '{0, -1,  0, -1, -1, 0, 0};
        vecs[1] = '{0,  2,  5, -1, -1, 1, 1};
        vecs[2] = '{1, -1,  0, -1, -1, 0, 0};
        vecs[3] = '{0, -1,  0,  0,  1, 2, 1};
        vecs[4] = '{1,  1, 14, -1,  1, 2, 1};
        vecs[5] = '{1,  3,  5,  1,  0, 3, 1};

        // Reset values.
        #2 rst = 1;
        #1;
        check("rst_valids", DW'({axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}), DW'(0));
        check("rst_flags", DW'({err_flag, heart_beat, test_busy}), DW'(0));
        check("rst_err_cnt", DW'(err_cnt), DW'(0));
        check("rst_pass_cnt", DW'(pass_cnt), DW'(0));
        repeat (2) @(negedge clk);
        #1 rst = 0;

        // Controller not calibrated: nothing may move.
        viol = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk); #1;
            if (axi.awvalid || axi.wvalid || axi.arvalid || axi.bready || axi.rready || test_busy || heart_beat) viol++;
        end
        check("idle_no_activity", DW'(viol), DW'(0));

        // Table of full-pass scenarios.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            stall = vecs[v].stall; corrupt_burst = vecs[v].corrupt_burst; corrupt_beat = vecs[v].corrupt_beat;
            bresp_burst = vecs[v].bresp_burst; early_burst = vecs[v].early_burst;
            @(negedge clk); #1 ddr_init_done = 1;
            wait_cond_pass1(6000);
            check($sformatf("v%0d_pass_cnt", v), DW'(pass_cnt), DW'(1));
            check($sformatf("v%0d_model_pass", v), DW'(pass_cnt), DW'(exp_pass));
            check($sformatf("v%0d_err_cnt", v), DW'(err_cnt), DW'(vecs[v].exp_err));
            check($sformatf("v%0d_err_flag", v), DW'(err_flag), DW'(vecs[v].exp_flag));
            check($sformatf("v%0d_busy", v), DW'(test_busy), DW'(1));
            hi = 0; tog = 0; hb_prev = heart_beat;
            for (int c = 0; c < 3 * HDIV; c++) begin
                @(negedge clk); #1;
                if (heart_beat) hi++;
                if (heart_beat != hb_prev) tog++;
                hb_prev = heart_beat;
            end
            if (vecs[v].exp_flag) check($sformatf("v%0d_heart_stuck", v), DW'(hi), DW'(3 * HDIV));
            else                  check($sformatf("v%0d_heart_blink", v), DW'(tog >= 2), DW'(1));
        end

        // Calibration lost mid-burst: burst finishes, then idle with state retained.
        do_reset();
        stall = 0; corrupt_burst = -1; bresp_burst = -1; early_burst = -1;
        @(negedge clk); #1 ddr_init_done = 1;
        hit = 0;
        for (int c = 0; c < 2000; c++) begin
            if (exp_burst == 1 && w_active && wbeat == 3) begin hit = 1; break; end
            @(negedge clk); #1;
        end
        check("drop_reached_w", DW'(hit), DW'(1));
        ddr_init_done = 0;
        hit = 0;
        for (int c = 0; c < 500; c++) begin
            if (!test_busy) begin hit = 1; break; end
            @(negedge clk); #1;
        end
        check("drop_went_idle", DW'(hit), DW'(1));
        check("drop_burst_done", DW'(exp_burst), DW'(2));
        repeat (3) @(negedge clk);
        #1;
        check("drop_heart_low", DW'(heart_beat), DW'(0));
        check("drop_quiet", DW'({axi.awvalid, axi.wvalid, axi.arvalid}), DW'(0));
        ddr_init_done = 1;
        hit = 0;
        for (int c = 0; c < 50; c++) begin
            if (axi.awvalid) begin hit = 1; break; end
            @(negedge clk); #1;
        end
        check("resume_aw", DW'(hit), DW'(1));
        check("resume_addr", DW'(axi.awaddr), DW'(2 * BL * BB));
        check("resume_err", DW'(err_cnt), DW'(0));

        // Reset in the middle of a W burst, second pass, burst 1, beat 7.
        do_reset();
        @(negedge clk); #1 ddr_init_done = 1;
        hit = 0;
        for (int c = 0; c < 6000; c++) begin
            if (pass_cnt == 16'd1 && exp_burst == 1 && w_active && wbeat == 7 && axi.wvalid) begin hit = 1; break; end
            @(negedge clk); #1;
        end
        check("midw_reached", DW'(hit), DW'(1));
        rst = 1;
        #1;
        check("midw_wvalid", DW'(axi.wvalid), DW'(0));
        check("midw_valids", DW'({axi.awvalid, axi.arvalid, axi.wlast}), DW'(0));
        check("midw_pass_cnt", DW'(pass_cnt), DW'(0));
        repeat (2) @(negedge clk);
        #1 rst = 0;
        hit = 0;
        for (int c = 0; c < 50; c++) begin
            if (axi.awvalid) begin hit = 1; break; end
            @(negedge clk); #1;
        end
        check("midw_restart_aw", DW'(hit), DW'(1));
        check("midw_restart_addr", DW'(axi.awaddr), DW'(0));
        check("midw_restart_pass", DW'(pass_cnt), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
